// File: rtl/mips_pkg.sv
// Shared MIPS register-file constants and the debug dump engine state encoding.
package mips_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } dump_state_t;

endpackage

// File: rtl/regfile_dump_if.sv
// Valid/ready beat stream carrying {addr, data} register dump beats toward the trace path.
interface regfile_dump_if
    import mips_pkg::*;
#(
    parameter int ADDR_W = REG_ADDR_W,
    parameter int DATA_W = REG_DATA_W
);

    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_addr;
    logic [DATA_W-1:0] out_data;

    modport master (
        output out_valid,
        output out_addr,
        output out_data,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_addr,
        input  out_data,
        output out_ready
    );

endinterface

// File: rtl/regfile_dump.sv
// Debug readout engine: walks a wrapping address range through a spare register-file
// read port and streams each register out as an {addr, data} beat.
module regfile_dump
    import mips_pkg::*;
#(
    parameter int ADDR_W    = REG_ADDR_W,
    parameter int DATA_W    = REG_DATA_W,
    parameter bit SKIP_ZERO = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W:0]   count,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    regfile_dump_if.master    stream,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W:0] FULL_COUNT = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE_LEFT   = {{ADDR_W{1'b0}}, 1'b1};

    dump_state_t       state;
    dump_state_t       state_next;
    logic [ADDR_W-1:0] cur;
    logic [ADDR_W:0]   remain;
    logic              pending;
    logic              last;
    logic              accept;
    logic              load;
    logic              skip;
    logic              valid_next;
    logic              done_next;

    // NOTE: every output of this block gets a default before the case so no path leaves a latch.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        load       = 1'b0;
        skip       = 1'b0;
        done_next  = 1'b0;
        // A beat is pending when it is shown but not taken this cycle; the slot is loadable otherwise.
        pending    = stream.out_valid && !stream.out_ready;
        last       = (remain == ONE_LEFT);

        case (state)
            IDLE: begin
                // The done cycle still counts as busy, so a start there is ignored.
                if (start && !done) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (SKIP_ZERO && (cur == '0)) begin
                    skip = 1'b1;
                    if (last) begin
                        state_next = pending ? DRAIN : IDLE;
                        done_next  = !pending;
                    end
                end else if (!pending) begin
                    load = 1'b1;
                    if (last) begin
                        state_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (stream.out_ready) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase

        valid_next = load || pending;
    end

    // NOTE: all clocked state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur              <= '0;
            remain           <= '0;
            stream.out_valid <= 1'b0;
            stream.out_addr  <= '0;
            stream.out_data  <= '0;
            done             <= 1'b0;
        end else begin
            done             <= done_next;
            stream.out_valid <= valid_next;

            if (accept) begin
                cur    <= start_addr;
                remain <= ((count == '0) || (count > FULL_COUNT)) ? FULL_COUNT : count;
            end else if (load || skip) begin
                cur    <= cur + 1'b1;
                remain <= remain - 1'b1;
            end

            // Data is taken live from the read port; writebacks during a dump are visible.
            if (load) begin
                stream.out_addr <= cur;
                stream.out_data <= rd_data;
            end
        end
    end

    assign rd_addr = cur;
    assign busy    = (state != IDLE) || done;

endmodule

// File: tb/tb_regfile_dump.sv
// Scoreboard bench for regfile_dump: one instance plain, one with SKIP_ZERO, sharing a register model.
module tb_regfile_dump;
    import mips_pkg::*;

    localparam int AW    = REG_ADDR_W;
    localparam int DW    = REG_DATA_W;
    localparam int NREGS = 2 ** AW;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } beat_t;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          start_a = 1'b0, start_b = 1'b0;
    logic [AW-1:0] sa_a = '0, sa_b = '0;
    logic [AW:0]   cnt_a = '0, cnt_b = '0;
    logic [AW-1:0] rd_addr_a, rd_addr_b;
    logic [DW-1:0] rd_data_a, rd_data_b;
    logic          busy_a, busy_b, done_a, done_b;
    logic [DW-1:0] regs [NREGS];

    int cyc      = 0;
    int checks   = 0;
    int failures = 0;
    int hs_a     = 0;
    int hs_b     = 0;

    beat_t q_a[$];
    beat_t q_b[$];

    regfile_dump_if #(.ADDR_W(AW), .DATA_W(DW)) st_a ();
    regfile_dump_if #(.ADDR_W(AW), .DATA_W(DW)) st_b ();

    assign rd_data_a = regs[rd_addr_a];
    assign rd_data_b = regs[rd_addr_b];

    regfile_dump #(.ADDR_W(AW), .DATA_W(DW), .SKIP_ZERO(1'b0)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .start_addr(sa_a), .count(cnt_a),
        .rd_addr(rd_addr_a), .rd_data(rd_data_a), .stream(st_a),
        .busy(busy_a), .done(done_a)
    );

    regfile_dump #(.ADDR_W(AW), .DATA_W(DW), .SKIP_ZERO(1'b1)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .start_addr(sa_b), .count(cnt_b),
        .rd_addr(rd_addr_b), .rd_data(rd_data_b), .stream(st_b),
        .busy(busy_b), .done(done_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // Monitor: pops the scoreboard on each handshake and checks beats stay put while stalled.
    logic          stall_a = 1'b0, stall_b = 1'b0;
    logic [AW-1:0] pa_a, pa_b;
    logic [DW-1:0] pd_a, pd_b;
    beat_t         exp_a, exp_b;

    always @(negedge clk) begin
        if (!rst_n) begin
            stall_a = 1'b0;
            stall_b = 1'b0;
        end else begin
            if (stall_a) begin
                checks++;
                if (st_a.out_valid !== 1'b1 || st_a.out_addr !== pa_a || st_a.out_data !== pd_a) begin
                    failures++;
                    $display("FAIL stable_a got v=%b a=%0d d=%h want v=1 a=%0d d=%h",
                             st_a.out_valid, st_a.out_addr, st_a.out_data, pa_a, pd_a);
                end
            end
            if (st_a.out_valid === 1'b1 && st_a.out_ready === 1'b1) begin
                hs_a++;
                checks++;
                if (q_a.size() == 0) begin
                    failures++;
                    $display("FAIL beat_a unexpected got a=%0d d=%h want none", st_a.out_addr, st_a.out_data);
                end else begin
                    exp_a = q_a.pop_front();
                    if (st_a.out_addr !== exp_a.a || st_a.out_data !== exp_a.d) begin
                        failures++;
                        $display("FAIL beat_a got a=%0d d=%h want a=%0d d=%h",
                                 st_a.out_addr, st_a.out_data, exp_a.a, exp_a.d);
                    end
                end
            end
            stall_a = st_a.out_valid && !st_a.out_ready;
            pa_a    = st_a.out_addr;
            pd_a    = st_a.out_data;

            if (stall_b) begin
                checks++;
                if (st_b.out_valid !== 1'b1 || st_b.out_addr !== pa_b || st_b.out_data !== pd_b) begin
                    failures++;
                    $display("FAIL stable_b got v=%b a=%0d d=%h want v=1 a=%0d d=%h",
                             st_b.out_valid, st_b.out_addr, st_b.out_data, pa_b, pd_b);
                end
            end
            if (st_b.out_valid === 1'b1 && st_b.out_ready === 1'b1) begin
                hs_b++;
                checks++;
                if (q_b.size() == 0) begin
                    failures++;
                    $display("FAIL beat_b unexpected got a=%0d d=%h want none", st_b.out_addr, st_b.out_data);
                end else begin
                    exp_b = q_b.pop_front();
                    if (st_b.out_addr !== exp_b.a || st_b.out_data !== exp_b.d) begin
                        failures++;
                        $display("FAIL beat_b got a=%0d d=%h want a=%0d d=%h",
                                 st_b.out_addr, st_b.out_data, exp_b.a, exp_b.d);
                    end
                end
            end
            stall_b = st_b.out_valid && !st_b.out_ready;
            pa_b    = st_b.out_addr;
            pd_b    = st_b.out_data;
        end
    end

    task automatic push_expected(input bit which, input logic [AW-1:0] sa, input logic [AW:0] cnt);
        int            n;
        logic [AW-1:0] a;
        beat_t         b;
        n = (cnt == 0 || int'(cnt) > NREGS) ? NREGS : int'(cnt);
        for (int i = 0; i < n; i++) begin
            a = AW'((int'(sa) + i) % NREGS);
            if (which && a == '0) continue;
            b.a = a;
            b.d = regs[a];
            if (which) q_b.push_back(b);
            else       q_a.push_back(b);
        end
    endtask

    // Pulses start for one cycle; n is the cycle number in which start is high.
    task automatic do_start(input bit which, input logic [AW-1:0] sa, input logic [AW:0] cnt, output int n);
        push_expected(which, sa, cnt);
        @(posedge clk); #1;
        n = cyc;
        if (which) begin start_b = 1'b1; sa_b = sa; cnt_b = cnt; end
        else       begin start_a = 1'b1; sa_a = sa; cnt_a = cnt; end
        @(posedge clk); #1;
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic wait_done(input bit which, output int at, output bit timed_out);
        timed_out = 1'b1;
        at        = -1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if ((which ? done_b : done_a) === 1'b1) begin
                at        = cyc;
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (rd_addr_a !== '0) begin failures++; $display("FAIL reset_rd_addr got %0d want 0", rd_addr_a); end
        checks++;
        if (st_a.out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got %b want 0", st_a.out_valid); end
        checks++;
        if (st_a.out_addr !== '0) begin failures++; $display("FAIL reset_out_addr got %0d want 0", st_a.out_addr); end
        checks++;
        if (st_a.out_data !== '0) begin failures++; $display("FAIL reset_out_data got %h want 0", st_a.out_data); end
        checks++;
        if (busy_a !== 1'b0 || done_a !== 1'b0) begin
            failures++; $display("FAIL reset_busy_done got %b%b want 00", busy_a, done_a);
        end
        checks++;
        if (st_b.out_valid !== 1'b0 || busy_b !== 1'b0) begin
            failures++; $display("FAIL reset_b got v=%b busy=%b want 0 0", st_b.out_valid, busy_b);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (busy_a !== 1'b0 || st_a.out_valid !== 1'b0) begin
            failures++; $display("FAIL post_reset_idle got busy=%b v=%b want 0 0", busy_a, st_a.out_valid);
        end
    endtask

    task automatic test_full_dump;
        int n, at, h0;
        bit to;
        h0 = hs_a;
        do_start(1'b0, 5'd0, 6'd0, n);
        @(negedge clk);
        checks++;
        if (busy_a !== 1'b1 || st_a.out_valid !== 1'b0) begin
            failures++; $display("FAIL full_n1 got busy=%b v=%b want 1 0", busy_a, st_a.out_valid);
        end
        @(negedge clk);
        checks++;
        if (st_a.out_valid !== 1'b1 || st_a.out_addr !== 5'd0) begin
            failures++; $display("FAIL full_first_beat got v=%b a=%0d want 1 0", st_a.out_valid, st_a.out_addr);
        end
        wait_done(1'b0, at, to);
        checks++;
        if (to || at != n + 34) begin failures++; $display("FAIL full_done_cycle got %0d want %0d", at - n, 34); end
        checks++;
        if (hs_a - h0 != 32) begin failures++; $display("FAIL full_beats got %0d want 32", hs_a - h0); end
        checks++;
        if (q_a.size() != 0) begin failures++; $display("FAIL full_left got %0d want 0", q_a.size()); end
    endtask

    task automatic test_wrap;
        int n, at, h0;
        bit to;
        h0 = hs_a;
        do_start(1'b0, 5'd30, 6'd4, n);
        wait_done(1'b0, at, to);
        checks++;
        if (to || at != n + 6) begin failures++; $display("FAIL wrap_done_cycle got %0d want 6", at - n); end
        checks++;
        if (hs_a - h0 != 4 || q_a.size() != 0) begin
            failures++; $display("FAIL wrap_beats got %0d left %0d want 4 left 0", hs_a - h0, q_a.size());
        end
    endtask

    task automatic test_backpressure;
        int n, at, h0;
        bit to;
        logic [4:0] pattern;
        pattern = 5'b11001;
        h0 = hs_a;
        do_start(1'b0, 5'd12, 6'd3, n);
        for (int i = 4; i >= 0; i--) begin
            @(posedge clk); #1;
            st_a.out_ready = pattern[i];
        end
        wait_done(1'b0, at, to);
        checks++;
        if (to || at != n + 7) begin failures++; $display("FAIL bp_done_cycle got %0d want 7", at - n); end
        checks++;
        if (hs_a - h0 != 3 || q_a.size() != 0) begin
            failures++; $display("FAIL bp_beats got %0d left %0d want 3 left 0", hs_a - h0, q_a.size());
        end
    endtask

    task automatic test_clamp_random;
        int n, h0;
        bit seen;
        seen = 1'b0;
        h0   = hs_a;
        do_start(1'b0, 5'd7, 6'd40, n);
        for (int i = 0; i < 600; i++) begin
            @(posedge clk); #1;
            st_a.out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (done_a === 1'b1) begin seen = 1'b1; break; end
        end
        st_a.out_ready = 1'b1;
        checks++;
        if (!seen) begin failures++; $display("FAIL clamp_done got none want pulse"); end
        checks++;
        if (hs_a - h0 != 32 || q_a.size() != 0) begin
            failures++; $display("FAIL clamp_beats got %0d left %0d want 32 left 0", hs_a - h0, q_a.size());
        end
    endtask

    task automatic test_skip_zero;
        int n, at, h0;
        bit to;
        h0 = hs_b;
        do_start(1'b1, 5'd31, 6'd3, n);
        wait_done(1'b1, at, to);
        checks++;
        if (to || at != n + 5) begin failures++; $display("FAIL skip_done_cycle got %0d want 5", at - n); end
        checks++;
        if (hs_b - h0 != 2 || q_b.size() != 0) begin
            failures++; $display("FAIL skip_beats got %0d left %0d want 2 left 0", hs_b - h0, q_b.size());
        end
        h0 = hs_b;
        do_start(1'b1, 5'd30, 6'd3, n);
        wait_done(1'b1, at, to);
        checks++;
        if (to || at != n + 4) begin failures++; $display("FAIL skip_last_done_cycle got %0d want 4", at - n); end
        checks++;
        if (hs_b - h0 != 2 || q_b.size() != 0) begin
            failures++; $display("FAIL skip_last_beats got %0d left %0d want 2 left 0", hs_b - h0, q_b.size());
        end
    endtask

    task automatic test_busy_start;
        int n, at, h0;
        bit to;
        h0 = hs_a;
        do_start(1'b0, 5'd10, 6'd5, n);
        @(posedge clk); #1;
        start_a = 1'b1; sa_a = 5'd20; cnt_a = 6'd2;
        @(posedge clk); #1;
        start_a = 1'b0;
        wait_done(1'b0, at, to);
        checks++;
        if (to || at != n + 7) begin failures++; $display("FAIL busy_done_cycle got %0d want 7", at - n); end
        checks++;
        if (busy_a !== 1'b1) begin failures++; $display("FAIL busy_in_done got %b want 1", busy_a); end
        @(negedge clk);
        checks++;
        if (busy_a !== 1'b0 || done_a !== 1'b0) begin
            failures++; $display("FAIL busy_after_done got busy=%b done=%b want 0 0", busy_a, done_a);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (st_a.out_valid !== 1'b0 || busy_a !== 1'b0) begin
            failures++; $display("FAIL busy_ignored_start got v=%b busy=%b want 0 0", st_a.out_valid, busy_a);
        end
        checks++;
        if (hs_a - h0 != 5 || q_a.size() != 0) begin
            failures++; $display("FAIL busy_beats got %0d left %0d want 5 left 0", hs_a - h0, q_a.size());
        end
    endtask

    task automatic test_back_to_back;
        int n1, n2, at1, at2;
        bit to1, to2;
        do_start(1'b0, 5'd3, 6'd2, n1);
        wait_done(1'b0, at1, to1);
        checks++;
        if (to1 || at1 != n1 + 4) begin failures++; $display("FAIL b2b_first_done got %0d want 4", at1 - n1); end
        do_start(1'b0, 5'd31, 6'd3, n2);
        wait_done(1'b0, at2, to2);
        checks++;
        if (to2 || at2 != n2 + 5) begin failures++; $display("FAIL b2b_second_done got %0d want 5", at2 - n2); end
        checks++;
        if (q_a.size() != 0) begin failures++; $display("FAIL b2b_left got %0d want 0", q_a.size()); end
    endtask

    task automatic test_reset_mid;
        int n, at;
        bit to;
        do_start(1'b0, 5'd0, 6'd8, n);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({rd_addr_a, st_a.out_valid, st_a.out_addr, st_a.out_data, busy_a, done_a} !== '0) begin
            failures++;
            $display("FAIL midreset_outputs got rd=%0d v=%b a=%0d d=%h busy=%b done=%b want all 0",
                     rd_addr_a, st_a.out_valid, st_a.out_addr, st_a.out_data, busy_a, done_a);
        end
        q_a.delete();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (done_a !== 1'b0 || st_a.out_valid !== 1'b0) begin
                failures++; $display("FAIL midreset_quiet got done=%b v=%b want 0 0", done_a, st_a.out_valid);
            end
        end
        @(posedge clk); #3;
        rst_n = 1'b1;
        do_start(1'b0, 5'd5, 6'd3, n);
        wait_done(1'b0, at, to);
        checks++;
        if (to || at != n + 5) begin failures++; $display("FAIL after_reset_done got %0d want 5", at - n); end
        checks++;
        if (q_a.size() != 0) begin failures++; $display("FAIL after_reset_left got %0d want 0", q_a.size()); end
    endtask

    initial begin
        for (int i = 0; i < NREGS; i++) regs[i] = $urandom;
        regs[17] = 32'd3;
        regs[18] = 32'd4;
        st_a.out_ready = 1'b1;
        st_b.out_ready = 1'b1;

        test_reset;
        test_full_dump;
        test_wrap;
        test_backpressure;
        test_clamp_random;
        test_skip_zero;
        test_busy_start;
        test_back_to_back;
        test_reset_mid;

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_dump.md
# regfile_dump

Debug readout engine for the 32x32 MIPS register file. On a `start` pulse it walks a contiguous, wrapping range of register addresses through one spare combinational read port and emits each register as a `{addr, data}` beat on a valid/ready stream toward the debug/trace path. It sits beside the register file and is the read-side counterpart of the writeback port. It never writes registers.

## Interface
- `ADDR_W`, 5: register address width; register count is 2^ADDR_W.
- `DATA_W`, 32: register data width.
- `SKIP_ZERO`, 0: when 1, address 0 is stepped over without emitting a beat; it still consumes one count.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: one-cycle request to begin a dump; ignored unless idle.
- `start_addr`  in  ADDR_W: first register address, sampled with `start`.
- `count`  in  ADDR_W+1: number of addresses to visit, sampled with `start`; 0 means 2^ADDR_W.
- `rd_addr`  out  ADDR_W: address to the register file read port; driven from a register.
- `rd_data`  in  DATA_W: combinational read data for `rd_addr`, valid in the same cycle.
- `out_valid`  out  1: beat available.
- `out_ready`  in  1: consumer accepts the beat.
- `out_addr`  out  ADDR_W: register address of the current beat.
- `out_data`  out  DATA_W: register contents of the current beat.
- `busy`  out  1: a dump is in progress.
- `done`  out  1: one-cycle pulse after the final beat is accepted.

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE: `busy`=0. On `start`, latch `cur`=`start_addr` and `remain`=`count`, mapping 0 to 2^ADDR_W. Go to RUN.
- RUN, load slot: the output register is loadable when `!out_valid || out_ready`.
  - When loadable, capture `rd_data`/`cur` into `out_data`/`out_addr`, set `out_valid`.
  - Then `cur`++ (mod 2^ADDR_W, wraps 31->0) and `remain`--.
  - If `SKIP_ZERO` and `cur`==0: advance `cur` and decrement `remain` without loading. If `out_ready` was high, `out_valid` clears.
- RUN -> DRAIN when `remain` reaches 0 on a load/skip.
- DRAIN: hold the final beat until `out_ready`. Then clear `out_valid`, pulse `done`, go to IDLE.
  - If the final step was a skip with nothing pending, go directly to IDLE with `done`.
- Handshake rules:
  - `out_addr`/`out_data` are stable while `out_valid && !out_ready`.
  - `out_valid` never drops without a handshake, except on reset.
- `rd_addr` always equals `cur`.
- Data is sampled at capture time. No snapshot is taken; concurrent writebacks may appear mid-dump.
- `start` while `busy`: ignored, no side effects.
- `count` > 2^ADDR_W is clamped to 2^ADDR_W.

## Timing
- Reset values: `rd_addr`=0, `out_valid`=0, `out_addr`=0, `out_data`=0, `busy`=0, `done`=0; state IDLE.
- Reset asserted mid-dump aborts immediately with no `done`.
- Latency: `start` in cycle N -> first `out_valid` in cycle N+2. N+1 is the RUN capture edge.
- Throughput: with `out_ready` held high, one beat per cycle.
- A dump of `count`=k with no skips and no backpressure asserts `done` in cycle N+k+2.
- `busy`=1 from cycle N+1 through the cycle `done` is high. A new `start` is accepted the following cycle.

## Structure
- Shared package `mips_pkg` holds `REG_ADDR_W`=5, `REG_DATA_W`=32, and the `dump_state_t` encoding (IDLE/RUN/DRAIN).
- No sub-module needed.
- The top-level instantiates one `regfile_dump`; its `rd_addr`/`rd_data` connect to a third register-file read port.

## Test plan
- Full dump: regs preset with r17=3 and r18=4; `start_addr`=0, `count`=0, `out_ready`=1.
  - Expect 32 consecutive beats, addresses 0..31, including (17,3) and (18,4).
  - Expect `done` 34 cycles after `start`.
- Wrap: `start_addr`=30, `count`=4 -> beats at addresses 30, 31, 0, 1, then `done`.
- Backpressure: `count`=3, toggle `out_ready` 1-0-0-1-1.
  - Expect beats held stable while stalled.
  - Expect exactly 3 handshakes and no dropped or duplicated addresses.
- SKIP_ZERO=1: `start_addr`=31, `count`=3 -> beats at 31 and 1 only; `done` after the address-1 handshake.
- Busy start and reset:
  - A second `start` during a 5-beat dump is ignored.
  - `rst_n` low mid-dump -> all outputs 0 immediately, no `done`.
  - A new `start` after release dumps correctly.
